// File: rtl/gpio_pattern_gen.sv
// GPIO test-pattern generator: walking-one, bounce and thermometer sequences,
// each iteration preceded by an all-zero gap step, paced by a prescaler.
module gpio_pattern_gen #(
  parameter int unsigned WIDTH      = 34,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned ITER_W     = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [ITER_W-1:0]     iterations,
  output logic [WIDTH-1:0]      pattern,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_W-1:0]     iter_count
);

  localparam int unsigned STEP_W      = $clog2(2 * WIDTH);
  localparam int unsigned WALK_LAST   = WIDTH - 1;
  localparam int unsigned BOUNCE_LAST = 2 * WIDTH - 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [ITER_W-1:0]     r_iterations;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [STEP_W-1:0]     r_step;
  logic [WIDTH-1:0]      r_pattern;
  logic                  r_busy;
  logic                  r_done;
  logic [ITER_W-1:0]     r_iter;

  logic                  w_tick;
  logic                  w_last_step;
  logic [STEP_W-1:0]     w_step_next;
  logic [ITER_W-1:0]     w_iter_next;
  logic                  w_hit;

  // Bus value for step index s of the latched mode.
  function automatic logic [WIDTH-1:0] step_pattern(input logic [1:0] m,
                                                    input logic [STEP_W-1:0] s);
    logic [WIDTH-1:0] one;
    one = WIDTH'(1);
    case (m)
      2'b00:   return one << s;
      2'b01:   return one << (STEP_W'(WIDTH - 1) - s);
      2'b10:   return (s < STEP_W'(WIDTH)) ? (one << s)
                                           : (one << (STEP_W'(2 * WIDTH - 2) - s));
      default: return ~({WIDTH{1'b1}} << (s + STEP_W'(1)));
    endcase
  endfunction

  assign w_tick      = (r_presc_cnt == '0);
  assign w_last_step = (r_step == ((r_mode == 2'b10) ? STEP_W'(BOUNCE_LAST)
                                                     : STEP_W'(WALK_LAST)));
  assign w_step_next = r_step + STEP_W'(1);
  assign w_iter_next = r_iter + ITER_W'(1);
  assign w_hit       = (r_iterations != '0) && (w_iter_next == r_iterations);

  // Sequencer; en low overrides everything except reset and freezes iter_count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'b00;
      r_prescale   <= '0;
      r_iterations <= '0;
      r_presc_cnt  <= '0;
      r_step       <= '0;
      r_pattern    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_iter       <= '0;
    end else if (!en) begin
      r_state     <= S_IDLE;
      r_presc_cnt <= '0;
      r_step      <= '0;
      r_pattern   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state      <= S_GAP;
            r_mode       <= mode;
            r_prescale   <= prescale;
            r_iterations <= iterations;
            r_presc_cnt  <= prescale;
            r_step       <= '0;
            r_pattern    <= '0;
            r_busy       <= 1'b1;
            r_iter       <= '0;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            r_state     <= S_RUN;
            r_presc_cnt <= r_prescale;
            r_step      <= '0;
            r_pattern   <= step_pattern(r_mode, STEP_W'(0));
          end else begin
            r_presc_cnt <= r_presc_cnt - PRESCALE_W'(1);
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_presc_cnt <= r_prescale;
            if (w_last_step) begin
              r_iter    <= w_iter_next;
              r_step    <= '0;
              r_pattern <= '0;
              if (w_hit) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_step    <= w_step_next;
              r_pattern <= step_pattern(r_mode, w_step_next);
            end
          end else begin
            r_presc_cnt <= r_presc_cnt - PRESCALE_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pattern    = r_pattern;
  assign busy       = r_busy;
  assign done       = r_done;
  assign iter_count = r_iter;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen: WIDTH=4 and WIDTH=34 instances checked cycle by
// cycle against a trace model built from step lists.
module tb_gpio_pattern_gen;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en4, start4, en34, start34;
  logic [1:0]  mode_i;
  logic [15:0] prescale_i;
  logic [7:0]  iterations_i;

  logic [3:0]  pat4;
  logic        busy4, done4;
  logic [7:0]  iter4;
  logic [33:0] pat34;
  logic        busy34, done34;
  logic [7:0]  iter34;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_pattern_gen #(.WIDTH(4), .PRESCALE_W(16), .ITER_W(8)) dut4 (
    .clk(clk), .nrst(nrst), .en(en4), .start(start4), .mode(mode_i),
    .prescale(prescale_i), .iterations(iterations_i),
    .pattern(pat4), .busy(busy4), .done(done4), .iter_count(iter4));

  gpio_pattern_gen #(.WIDTH(34), .PRESCALE_W(16), .ITER_W(8)) dut34 (
    .clk(clk), .nrst(nrst), .en(en34), .start(start34), .mode(mode_i),
    .prescale(prescale_i), .iterations(iterations_i),
    .pattern(pat34), .busy(busy34), .done(done34), .iter_count(iter34));

  typedef struct packed {
    logic [63:0] pat;
    logic        busy;
    logic        done;
    logic [7:0]  iter;
  } exp_t;

  typedef struct {
    bit         s34;
    logic [1:0] m;
    int         p;
    int         it;
    int         done_cyc;
  } vec_t;

  logic [63:0] m_steps[$];
  int          m_t;
  int          m_iters;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want,
                     input int c);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, want);
    end
  endtask

  // One iteration's step values, listed directly from the mode's definition.
  task automatic build_steps(input int w, input logic [1:0] m);
    logic [63:0] v;
    m_steps.delete();
    case (m)
      2'b00: begin v = 64'd1; repeat (w) begin m_steps.push_back(v); v = v * 2; end end
      2'b01: begin
        v = 64'd1 << (w - 1);
        repeat (w) begin m_steps.push_back(v); v = v / 2; end
      end
      2'b10: begin
        v = 64'd1;
        repeat (w) begin m_steps.push_back(v); v = v * 2; end
        v = (64'd1 << (w - 1)) / 2;
        repeat (w - 2) begin m_steps.push_back(v); v = v / 2; end
      end
      default: begin v = 64'd1; repeat (w) begin m_steps.push_back(v); v = v * 2 + 1; end end
    endcase
  endtask

  // Expected outputs in cycle c (c=1 is the first cycle after start is accepted).
  function automatic exp_t model_at(input int c);
    int   n, len, k, r;
    exp_t e;
    e   = '0;
    n   = m_steps.size();
    len = (n + 1) * m_t;
    if (m_iters != 0 && c > m_iters * len) begin
      e.done = (c == m_iters * len + 1);
      e.iter = 8'(m_iters);
    end else begin
      k      = (c - 1) / len;
      r      = (c - 1) % len;
      e.busy = 1'b1;
      e.iter = 8'(k);
      if (r >= m_t) e.pat = m_steps[r / m_t - 1];
    end
    return e;
  endfunction

  task automatic run(input bit s34, input logic [1:0] m, input int p, input int it,
                     input int cycles, input int exp_done, input int disturb_at);
    exp_t        e;
    int          seen;
    logic [63:0] op;
    logic        ob, od;
    logic [7:0]  oi;
    build_steps(s34 ? 34 : 4, m);
    m_t          = p + 1;
    m_iters      = it;
    mode_i       = m;
    prescale_i   = 16'(p);
    iterations_i = 8'(it);
    if (s34) start34 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4  = 1'b0;
    start34 = 1'b0;
    seen    = 0;
    for (int c = 1; c <= cycles; c++) begin
      e  = model_at(c);
      op = s34 ? 64'(pat34) : 64'(pat4);
      ob = s34 ? busy34 : busy4;
      od = s34 ? done34 : done4;
      oi = s34 ? iter34 : iter4;
      chk("pattern", op, e.pat, c);
      chk("busy", 64'(ob), 64'(e.busy), c);
      chk("done", 64'(od), 64'(e.done), c);
      chk("iter_count", 64'(oi), 64'(e.iter), c);
      if (od && seen == 0) seen = c;
      if (c == disturb_at) begin
        mode_i       = ~m;
        prescale_i   = 16'(p + 3);
        iterations_i = 8'(it + 5);
        if (s34) start34 = 1'b1; else start4 = 1'b1;
      end else if (c == disturb_at + 1) begin
        start4  = 1'b0;
        start34 = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (exp_done > 0) chk("done_cycle", 64'(seen), 64'(exp_done), cycles);
  endtask

  initial begin
    vec_t tbl[7];
    exp_t e;
    int   m, p, it, n, d;

    tbl[0] = '{1'b1, 2'b00, 0, 2, 71};
    tbl[1] = '{1'b0, 2'b10, 2, 1, 22};
    tbl[2] = '{1'b0, 2'b11, 0, 1, 6};
    tbl[3] = '{1'b0, 2'b01, 0, 1, 6};
    tbl[4] = '{1'b0, 2'b10, 0, 2, 15};
    tbl[5] = '{1'b0, 2'b11, 1, 3, 31};
    tbl[6] = '{1'b1, 2'b10, 0, 1, 68};

    nrst = 1'b0; en4 = 1'b0; en34 = 1'b0; start4 = 1'b0; start34 = 1'b0;
    mode_i = 2'b00; prescale_i = '0; iterations_i = '0;
    #12;
    chk("rst_pattern4", 64'(pat4), 64'd0, 0);
    chk("rst_busy4", 64'(busy4), 64'd0, 0);
    chk("rst_done4", 64'(done4), 64'd0, 0);
    chk("rst_iter4", 64'(iter4), 64'd0, 0);
    chk("rst_pattern34", 64'(pat34), 64'd0, 0);
    chk("rst_busy34", 64'(busy34), 64'd0, 0);
    nrst = 1'b1; en4 = 1'b1; en34 = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run(tbl[i].s34, tbl[i].m, tbl[i].p, tbl[i].it, tbl[i].done_cyc + 2, tbl[i].done_cyc, 0);

    for (int i = 0; i < 6; i++) begin
      m  = int'($urandom_range(0, 3));
      p  = int'($urandom_range(0, 3));
      it = int'($urandom_range(1, 3));
      n  = (m == 2) ? 6 : 4;
      d  = it * (n + 1) * (p + 1) + 1;
      run(1'b0, 2'(m), p, it, d + 2, d, 0);
    end

    // Restart in the first IDLE cycle after DONE.
    run(1'b0, 2'b11, 0, 1, 6, 6, 0);
    chk("idle_after_done_busy", 64'(busy4), 64'd0, 7);
    chk("idle_after_done_done", 64'(done4), 64'd0, 7);
    run(1'b0, 2'b01, 0, 1, 8, 6, 0);

    // Config changes and start pulses while busy are ignored.
    run(1'b0, 2'b01, 1, 2, 23, 21, 8);

    // Endless run, then en falls.
    run(1'b0, 2'b00, 0, 0, 130, 0, 0);
    e   = model_at(131);
    en4 = 1'b0;
    @(posedge clk); #1;
    chk("en_off_pattern", 64'(pat4), 64'd0, 132);
    chk("en_off_busy", 64'(busy4), 64'd0, 132);
    chk("en_off_done", 64'(done4), 64'd0, 132);
    chk("en_off_iter_hold", 64'(iter4), 64'(e.iter), 132);
    en4 = 1'b1;
    @(posedge clk); #1;

    // start and en falling together: en wins.
    start4 = 1'b1; en4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("start_en_low_busy", 64'(busy4), 64'd0, 1);
    en4 = 1'b1;
    @(posedge clk); #1;
    chk("start_en_low_busy_after", 64'(busy4), 64'd0, 2);
    chk("start_en_low_pattern", 64'(pat4), 64'd0, 2);

    // Asynchronous reset mid-step.
    run(1'b0, 2'b00, 2, 0, 20, 0, 0);
    chk("pre_rst_iter", 64'(iter4), 64'd1, 21);
    chk("pre_rst_pattern", 64'(pat4), 64'd1, 21);
    #1 nrst = 1'b0;
    #1;
    chk("async_rst_pattern", 64'(pat4), 64'd0, 21);
    chk("async_rst_busy", 64'(busy4), 64'd0, 21);
    chk("async_rst_iter", 64'(iter4), 64'd0, 21);
    chk("async_rst_done", 64'(done4), 64'd0, 21);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy4), 64'd0, 22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
